seq_detector: RTL and testbench



---
 rtl/seq_pkg.sv | 34 +++
 rtl/seq_detector_sat_counter.sv | 43 ++++
 rtl/seq_detector.sv | 120 ++++++++++++
 tb/tb_seq_detector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial sequence detector:
//   OVERLAP_ON / OVERLAP_OFF : detection-mode constants for seq_detector
//   DEF_PATTERN              : default 4-bit target pattern (1011)
//   phase_t                  : detector phase decoded from the fill level
//   clog2()                  : ceiling log2, used to size the fill counter
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam bit         OVERLAP_ON  = 1'b1;
  localparam bit         OVERLAP_OFF = 1'b0;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  // IDLE: no history, FILLING: partial history, ARMED: full history.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } phase_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, q <= 0
//   clr : synchronous clear; an increment in the same cycle still lands,
//         so the result is 1 when clr and inc are both high
//   inc : count one event
//   q   : current count, holds at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = CW'(inc);
    end else if (inc && (count_reg != {CW{1'b1}})) begin
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign q = count_reg;

endmodule

// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
// Serial sequence detector for a W-bit PATTERN (MSB = oldest bit).
// Parameters: W (2..32), PATTERN, OVERLAP (1 = overlapping matches,
// 0 = W fresh bits needed after a match), CW (match-counter width).
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   en          : din is consumed only when en=1
//   din         : serial data bit
//   clr         : synchronous clear of the match counter only
//   match_mealy : combinational, high while the completing bit is presented
//   match_moore : registered, high the cycle after a match_mealy cycle
//   fill        : number of valid history bits, 0..W
//   count       : saturating match count
// The fill level is the FSM state (IDLE / FILLING / ARMED); there is no
// separate state register.
// ---------------------------------------------------------------------------
module seq_detector
  import seq_pkg::*;
#(
  parameter int         W       = 4,
  parameter logic [W-1:0] PATTERN = DEF_PATTERN,
  parameter bit         OVERLAP = OVERLAP_ON,
  parameter int         CW      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   din,
  input  logic                   clr,
  output logic                   match_mealy,
  output logic                   match_moore,
  output logic [clog2(W+1)-1:0]  fill,
  output logic [CW-1:0]          count
);

  localparam int             FW        = clog2(W + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(W);
  localparam logic [FW-1:0]  FILL_LAST = FW'(W - 1);

  generate
    if (W < 2 || W > 32) begin : g_bad_w
      $error("seq_detector: W must be in 2..32");
    end
  endgenerate

  logic [W-1:0]  hist_reg, hist_next;
  logic [FW-1:0] fill_reg, fill_next;
  logic          moore_reg, moore_next;
  logic [W-1:0]  cand;
  logic          ready;
  logic          match;
  phase_t        phase;

  // Candidate window: history shifted left with the incoming bit at the LSB.
  assign cand[0] = din;
  generate
    for (genvar gi = 1; gi < W; gi++) begin : g_cand
      assign cand[gi] = hist_reg[gi-1];
    end
  endgenerate

  always_comb begin
    if (fill_reg == '0) begin
      phase = IDLE;
    end else if (fill_reg == FILL_FULL) begin
      phase = ARMED;
    end else begin
      phase = FILLING;
    end
  end

  // The window is fully valid once W-1 old bits plus the new bit are present.
  assign ready = (phase == ARMED) || (fill_reg == FILL_LAST);
  assign match = en & ~rst & ready & (cand == PATTERN);

  always_comb begin
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    moore_next = 1'b0;
    if (en) begin
      hist_next  = cand;
      moore_next = match;
      if (match) begin
        // Non-overlap restarts the fill so no bit of this match is reused.
        fill_next = OVERLAP ? FILL_FULL : '0;
      end else if (phase != ARMED) begin
        fill_next = fill_reg + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      moore_reg <= 1'b0;
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      moore_reg <= moore_next;
    end
  end

  sat_counter #(
    .CW(CW)
  ) u_count (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(match),
    .q  (count)
  );

  assign match_mealy = match;
  assign match_moore = moore_reg;
  assign fill        = fill_reg;

endmodule

// File: tb/tb_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_detector
// Four detector instances share one input stream:
//   0: W=4 1011 overlap   CW=8     1: W=4 1011 non-overlap CW=8
//   2: W=4 1011 non-overlap CW=2   3: W=3 101  overlap     CW=3
// A bit-history reference model checks every instance on every cycle;
// a vector table and hand-written sequences add explicit expectations.
// ---------------------------------------------------------------------------
module tb_seq_detector;

  localparam int NI = 4;
  localparam int W_A  [NI] = '{4, 4, 4, 3};
  localparam int PAT_A[NI] = '{11, 11, 11, 5};
  localparam int OV_A [NI] = '{1, 0, 0, 1};
  localparam int CW_A [NI] = '{8, 8, 2, 3};

  logic clk = 1'b0;
  logic rst, en, din, clr;

  logic       mealy0, mealy1, mealy2, mealy3;
  logic       moore0, moore1, moore2, moore3;
  logic [2:0] fill0, fill1, fill2;
  logic [1:0] fill3;
  logic [7:0] count0, count1;
  logic [1:0] count2;
  logic [2:0] count3;

  always #5 clk = ~clk;

  seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .match_mealy(mealy0), .match_moore(moore0), .fill(fill0), .count(count0));
  seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .match_mealy(mealy1), .match_moore(moore1), .fill(fill1), .count(count1));
  seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .match_mealy(mealy2), .match_moore(moore2), .fill(fill2), .count(count2));
  seq_detector #(.W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CW(3)) u_w3 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .match_mealy(mealy3), .match_moore(moore3), .fill(fill3), .count(count3));

  int total = 0;
  int bad   = 0;

  // Reference model: recent consumed bits, bits consumed since the last
  // reset / non-overlap restart, match count, and last cycle's match.
  longint unsigned m_hist[NI];
  int              m_nb[NI];
  int              m_cnt[NI];
  bit              m_prev[NI];

  // DUT values sampled by the most recent step.
  int s_mealy[NI], s_moore[NI], s_fill[NI], s_count[NI];

  typedef struct {
    bit r, e, d, c;
    int ov_mealy, ov_moore, ov_fill, ov_count;
    int no_mealy, no_moore, no_fill, no_count;
  } vec_t;
  vec_t vt[$];

  function automatic logic [63:0] dut_val(input int k, input int sel);
    logic [63:0] v;
    v = '0;
    case (k)
      0: v = (sel == 0) ? 64'(mealy0) : (sel == 1) ? 64'(moore0) : (sel == 2) ? 64'(fill0) : 64'(count0);
      1: v = (sel == 0) ? 64'(mealy1) : (sel == 1) ? 64'(moore1) : (sel == 2) ? 64'(fill1) : 64'(count1);
      2: v = (sel == 0) ? 64'(mealy2) : (sel == 1) ? 64'(moore2) : (sel == 2) ? 64'(fill2) : 64'(count2);
      default: v = (sel == 0) ? 64'(mealy3) : (sel == 1) ? 64'(moore3) : (sel == 2) ? 64'(fill3) : 64'(count3);
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_hist[k] = 0; m_nb[k] = 0; m_cnt[k] = 0; m_prev[k] = 0;
    end
  endtask

  // One clock cycle: drive inputs, compare all instances against the model
  // at the falling edge, advance the model, then move past the rising edge.
  task automatic step(input bit r, input bit e, input bit d, input bit c);
    bit              em;
    longint unsigned mask;
    int              efill;
    rst = r; en = e; din = d; clr = c;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      mask  = (64'd1 << W_A[k]) - 64'd1;
      em    = e && !r && (m_nb[k] >= W_A[k] - 1) &&
              ((((m_hist[k] << 1) | 64'(d)) & mask) == 64'(PAT_A[k]));
      efill = (m_nb[k] > W_A[k]) ? W_A[k] : m_nb[k];
      s_mealy[k] = int'(dut_val(k, 0));
      s_moore[k] = int'(dut_val(k, 1));
      s_fill[k]  = int'(dut_val(k, 2));
      s_count[k] = int'(dut_val(k, 3));
      check($sformatf("model_mealy%0d", k), dut_val(k, 0), 64'(em));
      check($sformatf("model_moore%0d", k), dut_val(k, 1), 64'(m_prev[k]));
      check($sformatf("model_fill%0d", k),  dut_val(k, 2), 64'(efill));
      check($sformatf("model_count%0d", k), dut_val(k, 3), 64'(m_cnt[k]));
      if (r) begin
        m_hist[k] = 0; m_nb[k] = 0; m_cnt[k] = 0; m_prev[k] = 0;
      end else begin
        m_prev[k] = em;
        if (c) m_cnt[k] = em ? 1 : 0;
        else if (em && m_cnt[k] < (1 << CW_A[k]) - 1) m_cnt[k]++;
        if (e) begin
          m_hist[k] = ((m_hist[k] << 1) | 64'(d)) & mask;
          if (em && OV_A[k] == 0) m_nb[k] = 0;
          else if (m_nb[k] < W_A[k]) m_nb[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    bit pat[4] = '{1, 0, 1, 1};
    bit prev_match;

    rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset rows hold everything at zero; then the 1011011 stream.
    vt.push_back('{1,1,1,0, 0,0,0,0, 0,0,0,0});
    vt.push_back('{1,1,0,0, 0,0,0,0, 0,0,0,0});
    vt.push_back('{1,1,1,0, 0,0,0,0, 0,0,0,0});
    vt.push_back('{1,1,1,0, 0,0,0,0, 0,0,0,0});
    vt.push_back('{0,1,1,0, 0,0,0,0, 0,0,0,0});
    vt.push_back('{0,1,0,0, 0,0,1,0, 0,0,1,0});
    vt.push_back('{0,1,1,0, 0,0,2,0, 0,0,2,0});
    vt.push_back('{0,1,1,0, 1,0,3,0, 1,0,3,0});
    vt.push_back('{0,1,0,0, 0,1,4,1, 0,1,0,1});
    vt.push_back('{0,1,1,0, 0,0,4,1, 0,0,1,1});
    vt.push_back('{0,1,1,0, 1,0,4,1, 0,0,2,1});
    vt.push_back('{0,0,0,0, 0,1,4,2, 0,0,3,1});
    vt.push_back('{0,0,1,0, 0,0,4,2, 0,0,3,1});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].e, vt[i].d, vt[i].c);
      $display("vector %0d rst=%0d en=%0d din=%0d ov:%0d/%0d/%0d/%0d no:%0d/%0d/%0d/%0d", i,
               vt[i].r, vt[i].e, vt[i].d, s_mealy[0], s_moore[0], s_fill[0], s_count[0],
               s_mealy[1], s_moore[1], s_fill[1], s_count[1]);
      check($sformatf("vec%0d_ov_mealy", i), 64'(s_mealy[0]), 64'(vt[i].ov_mealy));
      check($sformatf("vec%0d_ov_moore", i), 64'(s_moore[0]), 64'(vt[i].ov_moore));
      check($sformatf("vec%0d_ov_fill", i),  64'(s_fill[0]),  64'(vt[i].ov_fill));
      check($sformatf("vec%0d_ov_count", i), 64'(s_count[0]), 64'(vt[i].ov_count));
      check($sformatf("vec%0d_no_mealy", i), 64'(s_mealy[1]), 64'(vt[i].no_mealy));
      check($sformatf("vec%0d_no_moore", i), 64'(s_moore[1]), 64'(vt[i].no_moore));
      check($sformatf("vec%0d_no_fill", i),  64'(s_fill[1]),  64'(vt[i].no_fill));
      check($sformatf("vec%0d_no_count", i), 64'(s_count[1]), 64'(vt[i].no_count));
    end

    // Enable gaps: same stream with two idle cycles after every bit.
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, stream[i], 0);
      prev_match = (i == 3 || i == 6);
      check($sformatf("gap_bit%0d_mealy", i), 64'(s_mealy[0]), 64'(prev_match));
      for (int g = 0; g < 2; g++) begin
        step(0, 0, 1'($urandom_range(0, 1)), 0);
        check($sformatf("gap_bit%0d_idle%0d_moore", i, g), 64'(s_moore[0]),
              64'(prev_match && g == 0));
      end
      $display("gap bit %0d din=%0d count=%0d", i, stream[i], s_count[0]);
    end
    check("gap_count", 64'(s_count[0]), 64'd2);

    // Saturation and clear on the CW=2 non-overlap instance.
    step(1, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) step(0, 1, pat[b], 0);
      step(0, 0, 0, 0);
      $display("sat group %0d count=%0d", g, s_count[2]);
      check($sformatf("sat_count%0d", g), 64'(s_count[2]), 64'(sat_exp[g]));
    end
    for (int b = 0; b < 3; b++) step(0, 1, pat[b], 0);
    step(0, 1, 1, 1);
    check("sat_clr_match_mealy", 64'(s_mealy[2]), 64'd1);
    step(0, 0, 0, 0);
    $display("sat clr+match count=%0d", s_count[2]);
    check("sat_clr_match_count", 64'(s_count[2]), 64'd1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    $display("sat clr count=%0d", s_count[2]);
    check("sat_clr_count", 64'(s_count[2]), 64'd0);

    // Reset in the middle of a partial match.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    check("midrst_mealy_ov", 64'(s_mealy[0]), 64'd0);
    check("midrst_mealy_no", 64'(s_mealy[1]), 64'd0);
    step(0, 0, 0, 0);
    $display("mid reset fill=%0d count=%0d", s_fill[0], s_count[0]);
    check("midrst_fill", 64'(s_fill[0]), 64'd1);
    check("midrst_count", 64'(s_count[0]), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
    end
    $display("random phase counts %0d %0d %0d %0d", s_count[0], s_count[1], s_count[2], s_count[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
